// File: rtl/voxel_frame_sequencer.sv
// voxel_frame_sequencer
// Central sequencer for the voxel render path. Boots world generation once,
// then schedules raycaster frames, double-buffers the camera so the core only
// sees a new camera at a frame boundary, and drains queued host voxel writes
// into voxel memory only while the core is idle.
//
// Optional feature: define VOXEL_FRAME_STATS_EN to build the frame counter and
// the per-frame cycle counter. When it is undefined, frame_count and
// frame_cycles are tied to zero and no counter flops are built.
module voxel_frame_sequencer #(
  parameter int FIFO_DEPTH = 8,   // host write queue entries, power of 2, >= 2
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 64,
  parameter int CAM_W      = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_reset,
  output logic              world_start,
  input  logic              world_done,
  output logic              core_start,
  input  logic              core_busy,
  input  logic              core_done,
  output logic              frame_done,
  input  logic              auto_run,
  input  logic              start_frame_req,
  input  logic              cam_load,
  input  logic [CAM_W-1:0]  cam_in,
  output logic [CAM_W-1:0]  cam_active,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        seq_state,
  output logic [31:0]       frame_count,
  output logic [31:0]       frame_cycles
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WORLD  = 3'd1,
    S_IDLE   = 3'd2,
    S_LATCH  = 3'd3,
    S_START  = 3'd4,
    S_RENDER = 3'd5
  } state_e;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  // Boot camera: x/y/z = 10.0, dir = (1,0,0), plane = (0,0.664), Q8.8 each.
  localparam logic [CAM_W-1:0] CAM_DEFAULT = CAM_W'({
    16'h0A00, 16'h0A00, 16'h0A00, 16'h0100,
    16'h0000, 16'h0000, 16'h0000, 16'h00AA});

  state_e             state_q, state_d;
  logic               world_start_q, core_start_q, frame_done_q;
  logic               pending_q, pending_d;
  logic [CAM_W-1:0]   cam_stage_q, cam_stage_d;
  logic [CAM_W-1:0]   cam_active_q, cam_active_d;

  logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               fifo_empty, fifo_full, push, pop;

  logic               mem_wen_q;
  logic [ADDR_W-1:0]  mem_waddr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic               frame_done_set;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  // The queue refuses writes while restarting so a handshake is never dropped.
  assign wr_ready   = !fifo_full && (state_q != S_RESET) && !soft_reset;
  assign push       = wr_valid && wr_ready;
  // Memory writes happen only in S_IDLE, never while world_gen or the core own memory.
  assign pop        = (state_q == S_IDLE) && !fifo_empty && !soft_reset;

  assign frame_done_set = core_done && (state_q == S_RENDER) && !soft_reset;

  // Next-state logic for the sequencer FSM; soft_reset overrides every transition.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_RESET:  if (!core_busy) state_d = S_WORLD;
      S_WORLD:  if (world_done) state_d = S_IDLE;
      S_IDLE:   if (fifo_empty && !core_busy && (auto_run || pending_q)) state_d = S_LATCH;
      S_LATCH:  state_d = S_START;
      S_START:  state_d = S_RENDER;
      S_RENDER: if (core_done) state_d = S_IDLE;
      default:  state_d = S_RESET;
    endcase
    if (soft_reset) state_d = S_RESET;
  end

  // Next values of the start request flag and the two camera copies.
  always_comb begin
    pending_d    = pending_q;
    cam_stage_d  = cam_stage_q;
    cam_active_d = cam_active_q;
    if (start_frame_req && state_q != S_RESET) pending_d = 1'b1;
    else if (state_q == S_START)               pending_d = 1'b0;
    if (cam_load) cam_stage_d = cam_in;
    // A load arriving in the latch cycle itself bypasses the staging copy.
    if (state_q == S_LATCH) cam_active_d = cam_load ? cam_in : cam_stage_q;
    if (soft_reset) begin
      pending_d    = 1'b0;
      cam_stage_d  = CAM_DEFAULT;
      cam_active_d = CAM_DEFAULT;
    end
  end

  // Occupancy bookkeeping; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // FSM state, output pulses, start request and cameras.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RESET;
      world_start_q <= 1'b0;
      core_start_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      pending_q     <= 1'b0;
      cam_stage_q   <= CAM_DEFAULT;
      cam_active_q  <= CAM_DEFAULT;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      world_start_q <= (state_d == S_WORLD) && (state_q != S_WORLD);
      core_start_q  <= (state_d == S_START);
      frame_done_q  <= frame_done_set;
      pending_q     <= pending_d;
      cam_stage_q   <= cam_stage_d;
      cam_active_q  <= cam_active_d;
    end
  end

  // Queue storage: written on push only, contents are don't-care when empty.
  always_ff @(posedge clk) begin
    // NOTE: storage array has no reset; pointers and count define validity.
    if (push) fifo_mem[wr_ptr_q] <= {wr_addr, wr_data};
  end

  // Queue pointers and occupancy; soft_reset flushes the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (soft_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Registered voxel memory write port, one cycle behind the pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wen_q   <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_wen_q <= pop;
      if (pop) {mem_waddr_q, mem_wdata_q} <= fifo_mem[rd_ptr_q];
    end
  end

`ifdef VOXEL_FRAME_STATS_EN
  logic [31:0] frame_count_q, frame_cycles_q, cycle_cnt_q;

  // Frame statistics: cycle counter restarts at core_start and saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_q  <= '0;
      frame_cycles_q <= '0;
      cycle_cnt_q    <= '0;
    end else if (soft_reset) begin
      frame_count_q  <= '0;
      frame_cycles_q <= '0;
      cycle_cnt_q    <= '0;
    end else begin
      if (state_q == S_START)      cycle_cnt_q <= 32'd1;
      else if (cycle_cnt_q != '1)  cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (frame_done_set) begin
        frame_count_q  <= frame_count_q + 32'd1;
        frame_cycles_q <= cycle_cnt_q;
      end
    end
  end

  assign frame_count  = frame_count_q;
  assign frame_cycles = frame_cycles_q;
`else
  assign frame_count  = '0;
  assign frame_cycles = '0;
`endif

  assign world_start = world_start_q;
  assign core_start  = core_start_q;
  assign frame_done  = frame_done_q;
  assign cam_active  = cam_active_q;
  assign mem_wen     = mem_wen_q;
  assign mem_waddr   = mem_waddr_q;
  assign mem_wdata   = mem_wdata_q;
  assign seq_state   = state_q;

endmodule
